cbfp_denorm: RTL and testbench



---
 rtl/cbfp_pkg.sv | 25 ++
 rtl/cbfp_lane_shift.sv | 38 +++
 rtl/cbfp_denorm.sv | 109 ++++++++++
 tb/tb_cbfp_denorm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// Shared constants, FSM state type and exponent clamp helper for the CBFP denormaliser.
// Optional rounding is selected by CBFP_DENORM_ROUND_EN (see cbfp_lane_shift).
package cbfp_pkg;

    localparam int ARRAY_SIZE = 16;
    localparam int DIN_W      = 16;
    localparam int DOUT_W     = 13;
    localparam int EXP_W      = 5;
    localparam int BLK_BEATS  = 4;

    localparam int SHIFT_W = $clog2(DIN_W);
    localparam int CNT_W   = $clog2(BLK_BEATS + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Shifting a DIN_W-bit value by more than DIN_W-1 adds nothing, so clamp there.
    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [EXP_W-1:0] e);
        if (int'(e) > DIN_W - 1) return SHIFT_W'(DIN_W - 1);
        return SHIFT_W'(e);
    endfunction

endpackage

// File: rtl/cbfp_lane_shift.sv
// Per-lane combinational arithmetic right shift, optional round-half-up, and saturation.
// Rounding is enabled by defining CBFP_DENORM_ROUND_EN; otherwise the shift floors.
module cbfp_lane_shift
    import cbfp_pkg::*;
(
    input  logic signed [DIN_W-1:0]   din,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [DOUT_W-1:0]  dout
);

    localparam logic signed [DIN_W:0] MAX_V = (DIN_W + 1)'(2 ** (DOUT_W - 1) - 1);
    localparam logic signed [DIN_W:0] MIN_V = (DIN_W + 1)'(-(2 ** (DOUT_W - 1)));

    logic signed [DIN_W:0] ext;
    logic signed [DIN_W:0] rnd;
    logic signed [DIN_W:0] shf;

    // One guard bit keeps the rounding bias from overflowing the mantissa range.
    assign ext = {din[DIN_W-1], din};

`ifdef CBFP_DENORM_ROUND_EN
    assign rnd = (shift == '0) ? ext : ext + ((DIN_W + 1)'(1) <<< (shift - SHIFT_W'(1)));
`else
    assign rnd = ext;
`endif

    assign shf = rnd >>> shift;

    always_comb begin
        dout = shf[DOUT_W-1:0];
        if (shf > MAX_V) begin
            dout = MAX_V[DOUT_W-1:0];
        end else if (shf < MIN_V) begin
            dout = MIN_V[DOUT_W-1:0];
        end
    end

endmodule

// File: rtl/cbfp_denorm.sv
// Block-floating-point decoder: per-block exponent, 2-stage shift/round/saturate pipeline.
// Build option: CBFP_DENORM_ROUND_EN selects rounding instead of truncation in the lanes.
module cbfp_denorm
    import cbfp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     valid_in,
    input  logic                     sop_in,
    input  logic [EXP_W-1:0]         exp_in,
    input  logic signed [DIN_W-1:0]  din [ARRAY_SIZE],
    output logic signed [DOUT_W-1:0] dout [ARRAY_SIZE],
    output logic                     valid_out,
    output logic                     sop_out,
    output logic                     eop_out,
    output logic                     blk_err
);

    // Valid-only stream, no ready: a beat moves whenever valid_in is high, sop_in/exp_in
    // mean nothing without it, and valid_out/sop_out/eop_out mark the beat 2 cycles later.

    state_t                   state;
    logic [CNT_W-1:0]         beat_cnt;
    logic [EXP_W-1:0]         exp_q;
    logic                     s1_valid;
    logic                     s1_sop;
    logic                     s1_eop;
    logic [SHIFT_W-1:0]       s1_shift;
    logic signed [DIN_W-1:0]  s1_din   [ARRAY_SIZE];
    logic signed [DOUT_W-1:0] lane_out [ARRAY_SIZE];
    logic                     last_beat;

    assign last_beat = (beat_cnt == CNT_W'(BLK_BEATS - 1));

    // Framing FSM plus stage 1; a premature sop restarts the block from that beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            beat_cnt <= '0;
            exp_q    <= '0;
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_shift <= '0;
            blk_err  <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) s1_din[i] <= '0;
        end else begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            blk_err  <= 1'b0;
            if (valid_in) begin
                if (sop_in) begin
                    blk_err  <= (state == ACTIVE);
                    exp_q    <= exp_in;
                    s1_valid <= 1'b1;
                    s1_sop   <= 1'b1;
                    s1_shift <= clamp_shift(exp_in);
                    s1_din   <= din;
                    if (BLK_BEATS == 1) begin
                        s1_eop   <= 1'b1;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        beat_cnt <= CNT_W'(1);
                        state    <= ACTIVE;
                    end
                end else if (state == IDLE) begin
                    blk_err <= 1'b1;
                end else begin
                    s1_valid <= 1'b1;
                    s1_shift <= clamp_shift(exp_q);
                    s1_din   <= din;
                    if (last_beat) begin
                        s1_eop   <= 1'b1;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        cbfp_lane_shift u_lane (
            .din  (s1_din[i]),
            .shift(s1_shift),
            .dout (lane_out[i])
        );
    end

    // Stage 2: dout only updates on a valid beat so it holds through gaps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) dout[i] <= '0;
        end else begin
            valid_out <= s1_valid;
            sop_out   <= s1_valid & s1_sop;
            eop_out   <= s1_valid & s1_eop;
            if (s1_valid) dout <= lane_out;
        end
    end

endmodule

// File: tb/tb_cbfp_denorm.sv
// Self-checking bench for cbfp_denorm: directed steps, a framing/arithmetic reference
// model feeding an expected-beat queue, and per-cycle checks of valid_out and blk_err.
module tb_cbfp_denorm;
    import cbfp_pkg::*;

    localparam int PW = ARRAY_SIZE * DOUT_W + 2;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic                     valid_in;
    logic                     sop_in;
    logic [EXP_W-1:0]         exp_in;
    logic signed [DIN_W-1:0]  din  [ARRAY_SIZE];
    logic signed [DOUT_W-1:0] dout [ARRAY_SIZE];
    logic                     valid_out;
    logic                     sop_out;
    logic                     eop_out;
    logic                     blk_err;

    cbfp_denorm dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (valid_in),
        .sop_in   (sop_in),
        .exp_in   (exp_in),
        .din      (din),
        .dout     (dout),
        .valid_out(valid_out),
        .sop_out  (sop_out),
        .eop_out  (eop_out),
        .blk_err  (blk_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] exp_q[$];
    int            t_q[$];
    int            err_q[$];

    bit m_active = 1'b0;
    int m_cnt    = 0;
    int m_exp    = 0;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DOUT_W-1:0] ref_lane(input int d, input int e);
        int s;
        int v;
        s = (e > DIN_W - 1) ? DIN_W - 1 : e;
        v = d;
`ifdef CBFP_DENORM_ROUND_EN
        if (s > 0) v = v + (1 << (s - 1));
`endif
        v = v >>> s;
        if (v > 2 ** (DOUT_W - 1) - 1) v = 2 ** (DOUT_W - 1) - 1;
        if (v < -(2 ** (DOUT_W - 1))) v = -(2 ** (DOUT_W - 1));
        return v[DOUT_W-1:0];
    endfunction

    function automatic logic [PW-1:0] pack_obs();
        logic [PW-1:0] w;
        w = '0;
        w[PW-1] = sop_out;
        w[PW-2] = eop_out;
        for (int i = 0; i < ARRAY_SIZE; i++) w[i*DOUT_W +: DOUT_W] = dout[i];
        return w;
    endfunction

    // One input cycle; lanes 2.. get random mantissas, the model decides framing.
    task automatic drive(input bit v, input bit s, input int e, input int l0, input int l1);
        int            lane_v [ARRAY_SIZE];
        logic [PW-1:0] w;
        bit            acc;
        bit            eop;
        valid_in = v;
        sop_in   = s;
        exp_in   = EXP_W'(e);
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            lane_v[i] = (i == 0) ? l0 : (i == 1) ? l1 : int'($urandom_range(0, 65535)) - 32768;
            din[i]    = DIN_W'(lane_v[i]);
        end
        acc = 1'b0;
        eop = 1'b0;
        if (v) begin
            if (s) begin
                if (m_active) err_q.push_back(cyc + 1);
                m_exp    = e;
                m_cnt    = 1;
                m_active = 1'b1;
                acc      = 1'b1;
            end else if (!m_active) begin
                err_q.push_back(cyc + 1);
            end else begin
                m_cnt++;
                acc = 1'b1;
            end
            if (acc && m_cnt == BLK_BEATS) begin
                eop      = 1'b1;
                m_active = 1'b0;
                m_cnt    = 0;
            end
        end
        if (acc) begin
            w = '0;
            w[PW-1] = s;
            w[PW-2] = eop;
            for (int i = 0; i < ARRAY_SIZE; i++) w[i*DOUT_W +: DOUT_W] = ref_lane(lane_v[i], m_exp);
            exp_q.push_back(w);
            t_q.push_back(cyc + 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 0, 0);
    endtask

    task automatic block(input int e, input int l0, input int l1, input int gap);
        drive(1'b1, 1'b1, e, l0, l1);
        for (int b = 1; b < BLK_BEATS; b++) begin
            idle(gap);
            drive(1'b1, 1'b0, int'($urandom_range(0, 31)), l0, l1);
        end
    endtask

    // Every out-of-reset cycle: valid_out and blk_err must match the model exactly.
    always @(negedge clk) begin
        if (rstn) begin
            bit exp_v;
            bit exp_e;
            exp_e = (err_q.size() > 0 && err_q[0] == cyc);
            chk("blk_err", PW'(blk_err), PW'(exp_e));
            if (exp_e) void'(err_q.pop_front());
            exp_v = (t_q.size() > 0 && t_q[0] == cyc);
            chk("valid_out", PW'(valid_out), PW'(exp_v));
            if (exp_v) begin
                void'(t_q.pop_front());
                chk("beat", pack_obs(), exp_q.pop_front());
            end
        end
    end

    initial begin
        rstn     = 1'b0;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        exp_in   = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) din[i] = '0;
        #2;
        chk("rst_valid_out", PW'(valid_out), PW'(0));
        chk("rst_blk_err", PW'(blk_err), PW'(0));
        chk("rst_outputs", pack_obs(), PW'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Truncation / rounding block, back-to-back beats.
        block(3, 1000, -1001, 0);
        idle(3);
        chk("blk_l0", PW'(int'(dout[0])), PW'(125));
`ifdef CBFP_DENORM_ROUND_EN
        chk("blk_l1", PW'(int'(dout[1])), PW'(-125));
`else
        chk("blk_l1", PW'(int'(dout[1])), PW'(-126));
`endif

        // Saturation at exp 0, then exponent clamp at 20 -> 15.
        block(0, 20000, -20000, 0);
        idle(3);
        chk("sat_pos", PW'(int'(dout[0])), PW'(4095));
        chk("sat_neg", PW'(int'(dout[1])), PW'(-4096));
        block(20, -1, -1, 0);
        idle(3);
`ifdef CBFP_DENORM_ROUND_EN
        chk("clamp_l0", PW'(int'(dout[0])), PW'(0));
`else
        chk("clamp_l0", PW'(int'(dout[0])), PW'(-1));
`endif

        // Gapped input, two idle cycles between beats.
        block(5, 12345, -321, 2);
        idle(3);

        // Premature sop after two beats.
        drive(1'b1, 1'b1, 2, 777, -777);
        drive(1'b1, 1'b0, 9, 777, -777);
        block(1, -5, 5, 0);
        idle(3);

        // Orphan beats while idle.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 4, 100, -100);
        idle(3);

        // Reset in the middle of a block.
        drive(1'b1, 1'b1, 4, 3000, -3000);
        drive(1'b1, 1'b0, 4, 3000, -3000);
        valid_in = 1'b0;
        rstn     = 1'b0;
        #1;
        chk("rst_mid_outputs", pack_obs(), PW'(0));
        chk("rst_mid_valid", PW'(valid_out), PW'(0));
        exp_q.delete();
        t_q.delete();
        err_q.delete();
        m_active = 1'b0;
        m_cnt    = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        drive(1'b1, 1'b0, 4, 50, -50);
        drive(1'b1, 1'b0, 4, 50, -50);
        block(6, -32768, 32767, 1);
        idle(4);

        chk("exp_q_drained", PW'(exp_q.size()), PW'(0));
        chk("err_q_drained", PW'(err_q.size()), PW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
